// File: rtl/rom_prefetch.sv
// Two-slot ROM read buffer in front of the SDRAM romrd toggle port: one demand slot, one
// prefetch slot, a single outstanding transfer, and hit/miss statistics.
module rom_prefetch #(
  parameter bit PREFETCH_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic [22:0] cpu_a,
  output logic [15:0] cpu_q,
  output logic        cpu_ack,
  input  logic        flush,
  output logic        romrd_req,
  input  logic        romrd_ack,
  output logic [22:0] romrd_a,
  input  logic [15:0] romrd_q,
  output logic [15:0] hit_cnt,
  output logic [15:0] miss_cnt
);

  typedef enum logic [2:0] {
    StIdle,
    StDemand,
    StPref,
    StPrefWait,
    StDone
  } state_e;

  state_e      state_q;

  // Registered copies of the bus inputs; the FSM decides on these only.
  logic        req_q;
  logic [22:0] a_q;
  logic        ack_q;
  logic [15:0] rdata_q;

  // Current cpu_req high period has already been acknowledged.
  logic        acked_q;
  // Outstanding transfer was overtaken by a flush; its data must not be cached.
  logic        drop_q;

  logic        d_valid_q;
  logic [22:0] d_tag_q;
  logic [15:0] d_data_q;
  logic        p_valid_q;
  logic [22:0] p_tag_q;
  logic [15:0] p_data_q;

  logic        d_hit;
  logic        p_hit;
  logic        hit;
  logic [15:0] hit_data;
  logic        new_req;
  logic        xfer_done;
  logic        keep;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_comb begin
    d_hit     = d_valid_q && (d_tag_q == a_q) && !flush;
    p_hit     = p_valid_q && (p_tag_q == a_q) && !flush;
    hit       = d_hit || p_hit;
    hit_data  = d_hit ? d_data_q : p_data_q;
    new_req   = req_q && !acked_q;
    xfer_done = (romrd_req == ack_q);
    keep      = !drop_q && !flush;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      req_q     <= 1'b0;
      a_q       <= '0;
      ack_q     <= 1'b0;
      rdata_q   <= '0;
      acked_q   <= 1'b0;
      drop_q    <= 1'b0;
      d_valid_q <= 1'b0;
      d_tag_q   <= '0;
      d_data_q  <= '0;
      p_valid_q <= 1'b0;
      p_tag_q   <= '0;
      p_data_q  <= '0;
      cpu_q     <= '0;
      cpu_ack   <= 1'b0;
      romrd_req <= 1'b0;
      romrd_a   <= '0;
      hit_cnt   <= '0;
      miss_cnt  <= '0;
    end else begin
      req_q   <= cpu_req;
      a_q     <= cpu_a;
      ack_q   <= romrd_ack;
      rdata_q <= romrd_q;
      cpu_ack <= 1'b0;
      if (!req_q) acked_q <= 1'b0;
      if (flush) drop_q <= 1'b1;

      unique case (state_q)
        StIdle: begin
          if (new_req) begin
            if (hit) begin
              cpu_ack <= 1'b1;
              cpu_q   <= hit_data;
              acked_q <= 1'b1;
              hit_cnt <= sat_inc(hit_cnt);
              state_q <= StDone;
            end else begin
              romrd_req <= ~romrd_req;
              romrd_a   <= a_q;
              drop_q    <= flush;
              miss_cnt  <= sat_inc(miss_cnt);
              state_q   <= StDemand;
            end
          end
        end

        StDemand: begin
          if (xfer_done) begin
            if (keep) begin
              d_valid_q <= 1'b1;
              d_tag_q   <= romrd_a;
              d_data_q  <= rdata_q;
            end
            cpu_ack <= 1'b1;
            cpu_q   <= rdata_q;
            acked_q <= 1'b1;
            if (PREFETCH_EN) begin
              romrd_req <= ~romrd_req;
              romrd_a   <= romrd_a + 23'd1;
              drop_q    <= flush;
              state_q   <= StPref;
            end else begin
              state_q <= StDone;
            end
          end
        end

        StPref: begin
          if (xfer_done) begin
            if (keep) begin
              p_valid_q <= 1'b1;
              p_tag_q   <= romrd_a;
              p_data_q  <= rdata_q;
            end
            if (new_req && (a_q == romrd_a)) begin
              cpu_ack <= 1'b1;
              cpu_q   <= rdata_q;
              acked_q <= 1'b1;
              hit_cnt <= sat_inc(hit_cnt);
              state_q <= StDone;
            end else if (req_q && acked_q) begin
              state_q <= StDone;
            end else begin
              // A still-waiting unrelated request takes the miss path from idle.
              state_q <= StIdle;
            end
          end else if (new_req) begin
            if (hit) begin
              cpu_ack <= 1'b1;
              cpu_q   <= hit_data;
              acked_q <= 1'b1;
              hit_cnt <= sat_inc(hit_cnt);
            end else if (a_q == romrd_a) begin
              state_q <= StPrefWait;
            end
          end
        end

        StPrefWait: begin
          if (xfer_done) begin
            if (keep) begin
              p_valid_q <= 1'b1;
              p_tag_q   <= romrd_a;
              p_data_q  <= rdata_q;
            end
            cpu_ack <= 1'b1;
            cpu_q   <= rdata_q;
            acked_q <= 1'b1;
            hit_cnt <= sat_inc(hit_cnt);
            state_q <= StDone;
          end
        end

        StDone: begin
          if (!req_q) state_q <= StIdle;
        end

        default: state_q <= StIdle;
      endcase

      // Flush wins over any slot write in the same cycle.
      if (flush) begin
        d_valid_q <= 1'b0;
        p_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: doc/rom_prefetch.md
# rom_prefetch

Two-entry ROM read buffer between the 68k/Z80 cartridge bus logic and the `romrd_*` toggle port of the SDRAM controller. It turns the level-held CPU read strobe into a single toggle request, and answers repeated or sequential reads from a small buffer without an SDRAM round trip. After each demand fill it speculatively fetches the next word. It is flushed whenever ROM contents change (ROM download, mapper bank switch).

## Interface
Parameters:
- `PREFETCH_EN`, default 1: 1 means a prefetch of addr+1 follows every demand fill; 0 disables prefetch.

Ports:
- `clk`  in  1  system clock, same clock as the SDRAM controller.
- `rst`  in  1  asynchronous, active-high reset.
- `cpu_req`  in  1  level read request; held until `cpu_ack` is seen, then dropped.
- `cpu_a`  in  23  word address [23:1]; stable while `cpu_req` is high.
- `cpu_q`  out  16  read data; valid in the `cpu_ack` cycle and held until the next ack.
- `cpu_ack`  out  1  one-cycle completion pulse.
- `flush`  in  1  one-cycle pulse that invalidates the buffer.
- `romrd_req`  out  1  toggle request to the SDRAM port.
- `romrd_ack`  in  1  toggle acknowledge; a transfer is complete when `romrd_ack == romrd_req`.
- `romrd_a`  out  23  SDRAM word address [23:1]; stable while a transfer is outstanding.
- `romrd_q`  in  16  SDRAM data; valid in the cycle `romrd_ack` becomes equal to `romrd_req`.
- `hit_cnt`  out  16  saturating count of buffer hits.
- `miss_cnt`  out  16  saturating count of demand fetches.

## Operation
- Storage has two slots, each holding a valid bit, a 23-bit tag and 16-bit data.
  - Slot D holds the last demand fill.
  - Slot P holds the last prefetch fill.
- A hit means `cpu_a` matches the tag of a valid slot. If both slots match, slot D supplies the data.
- States:
  - IDLE: no transfer outstanding.
  - DEMAND: demand transfer outstanding.
  - PREF: prefetch outstanding, no CPU wait.
  - PREF_WAIT: prefetch outstanding, and the CPU is waiting.
  - DONE: ack given; waiting for `cpu_req` to go low.
- In IDLE with `cpu_req` high:
  - On a hit: pulse `cpu_ack` with the slot data, increment `hit_cnt`, go to DONE.
  - On a miss: toggle `romrd_req`, set `romrd_a = cpu_a`, increment `miss_cnt`, go to DEMAND.
- On DEMAND completion:
  - Write `romrd_q` to slot D and pulse `cpu_ack` with `cpu_q = romrd_q`.
  - If `PREFETCH_EN`: in the same cycle, toggle `romrd_req` with `romrd_a = cpu_a + 1`, with wrap 0x7FFFFF -> 0x000000. Go to PREF; while `cpu_req` is still high, DONE semantics apply (no new ack is issued until `cpu_req` has dropped).
  - Otherwise go to DONE.
- In PREF with a new `cpu_req`:
  - If it hits a valid slot: serve it as in IDLE. The prefetch stays outstanding.
  - If `cpu_a` equals the prefetch address: go to PREF_WAIT. On completion, fill slot P, pulse `cpu_ack` with `romrd_q`, count as a hit, and do not chain a new prefetch.
  - Otherwise (a toggle cannot be cancelled): on completion, fill slot P, then issue the demand on the next cycle, following the miss path.
- On PREF completion with no CPU waiting: fill slot P and go to IDLE (or DONE if `cpu_req` is still high from the previous ack).
- DONE goes to IDLE when `cpu_req` is low. At most one `cpu_ack` is issued per `cpu_req` high period.
- `flush`:
  - Clears both valid bits immediately.
  - Data of any transfer already outstanding is not written to a slot, but a waiting CPU still receives it.
  - `flush` does not disturb `romrd_req`/`romrd_ack` parity.
  - If `flush` and a slot write occur in the same cycle, the slot ends invalid.
- Counters saturate at 0xFFFF and clear only on `rst`.

## Timing
- Reset values:
  - `romrd_req` = 0, `romrd_a` = 0, `cpu_ack` = 0, `cpu_q` = 0.
  - Both valid bits = 0; state = IDLE; counters = 0.
  - The SDRAM port toggle state must also come up at 0 so that parity matches.
- Hit latency: `cpu_req` first sampled high at edge N gives `cpu_ack` high after edge N+1.
- Miss latency: `romrd_req` toggles at edge N+1. If the ack parity matches at edge M, `cpu_ack` and `cpu_q` register at edge M+1. The prefetch toggle also registers at edge M+1.
- At most one SDRAM transfer is outstanding at any time.
- `rst` mid-transfer: all state returns to reset values and the late ack is ignored by construction. The SDRAM side must be reset together with this block.

## Test plan
- Miss then hit: read 0x000100 (SDRAM returns 0xA55A). Expect one `romrd_req` toggle with `romrd_a` = 0x000100, and `cpu_ack` one cycle after the ack. Re-read 0x000100: `cpu_ack` 1 cycle after req, no toggle, `hit_cnt` = 1.
- Sequential: read 0x000200, then 0x000201 after the prefetch completes. Expect the second read to hit slot P with zero extra toggles; `miss_cnt` = 1.
- Prefetch in flight: issue the read of 0x000301 while the prefetch of 0x000301 is outstanding. Expect PREF_WAIT, `cpu_ack` one cycle after the ack, and exactly 2 toggles total.
- Prefetch conflict: request 0x001000 while the prefetch of 0x000401 is pending. Expect the prefetch to complete into slot P, then a demand toggle with `romrd_a` = 0x001000.
- Wrap and flush: read 0x7FFFFF and expect the prefetch address 0x000000. Pulse `flush` before the prefetch ack, then read 0x000000: expect a miss (new toggle).
- Reset mid-DEMAND: assert `rst`. Expect all outputs at their reset values, and `cpu_ack` never pulses for the aborted read.
